// File: rtl/spike_residue_sched.sv
// spike_residue_sched: one threshold/residue datapath shared by NUM_NEURONS
// neurons. Each accepted partial sum is added to the neuron's residue. A sum
// that crosses the threshold emits a spike and keeps the excess as the new
// residue. Timestep ends either acknowledge immediately or sweep the residues
// back to zero first.
module spike_residue_sched #(
  parameter int WIDTH       = 8,
  parameter int NUM_NEURONS = 4,
  parameter int ID_W        = 2,
  parameter int THRESHOLD   = 64,
  parameter bit CLEAR_ON_TS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_threshold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ID_W-1:0]  in_id,
  input  logic [WIDTH-1:0] in_psum,
  output logic             spk_valid,
  input  logic             spk_ready,
  output logic [ID_W-1:0]  spk_id,
  input  logic             ts_end,
  output logic             ts_done,
  output logic             busy
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_CALC, S_SPIKE} state_t;

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_NEURONS - 1);
  localparam logic [ID_W:0]   NN       = (ID_W + 1)'(NUM_NEURONS);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   clr_idx_q, clr_idx_d;
  logic              pend_q, pend_d;
  logic              ts_clr_q, ts_clr_d;
  logic [WIDTH-1:0]  thr_q;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  psum_q, psum_d;
  logic [WIDTH-1:0]  res_q [NUM_NEURONS];

  logic              id_ok;
  logic [WIDTH-1:0]  rd_res;
  logic [WIDTH-1:0]  sum_c;
  logic              fire_c;
  logic              wr_en;
  logic [ID_W-1:0]   wr_idx;
  logic [WIDTH-1:0]  wr_data;
  logic              ts_done_c;

  // Unsigned add at WIDTH+1 bits, clamped to all-ones on carry out.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  assign in_ready  = (state_q == S_IDLE) && !pend_q && !ts_end;
  assign spk_valid = (state_q == S_SPIKE);
  assign spk_id    = (state_q == S_SPIKE) ? id_q : '0;
  assign busy      = (state_q != S_IDLE);
  assign ts_done   = ts_done_c;
  assign id_ok     = ({1'b0, id_q} < NN);

  // Residue read mux; out-of-range ids read zero and are never written.
  always_comb begin
    rd_res = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (id_q == ID_W'(i)) rd_res = res_q[i];
    end
  end

  assign sum_c  = sat_add(rd_res, psum_q);
  assign fire_c = (sum_c > thr_q);

  // Next-state, residue write port and timestep acknowledge.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    pend_d    = pend_q | ts_end;
    ts_clr_d  = ts_clr_q;
    id_d      = id_q;
    psum_d    = psum_q;
    wr_en     = 1'b0;
    wr_idx    = id_q;
    wr_data   = sum_c;
    ts_done_c = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_idx  = clr_idx_q;
        wr_data = '0;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = S_IDLE;
          clr_idx_d = '0;
          ts_done_c = ts_clr_q;
          ts_clr_d  = 1'b0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (pend_q) begin
          // A ts_end arriving in this same cycle collapses into this service.
          pend_d = 1'b0;
          if (CLEAR_ON_TS) begin
            state_d   = S_CLEAR;
            clr_idx_d = '0;
            ts_clr_d  = 1'b1;
          end else begin
            ts_done_c = 1'b1;
          end
        end else if (in_valid && in_ready) begin
          id_d    = in_id;
          psum_d  = in_psum;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        state_d = S_IDLE;
        if (id_ok) begin
          wr_en = 1'b1;
          if (fire_c) begin
            wr_data = sum_c - thr_q;
            state_d = S_SPIKE;
          end
        end
      end
      S_SPIKE: begin
        if (spk_ready) state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Control registers: FSM, clear index, pending timestep flag, threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      pend_q    <= 1'b0;
      ts_clr_q  <= 1'b0;
      thr_q     <= WIDTH'(THRESHOLD);
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      pend_q    <= pend_d;
      ts_clr_q  <= ts_clr_d;
      if (cfg_we) thr_q <= cfg_threshold;
    end
  end

  // Datapath registers: captured request and per-neuron residues.
  always_ff @(posedge clk) begin
    id_q   <= id_d;
    psum_q <= psum_d;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (wr_en && (wr_idx == ID_W'(i))) res_q[i] <= wr_data;
    end
  end

endmodule

// File: tb/tb_spike_residue_sched.sv
// Directed bench for spike_residue_sched: three instances (default, clear on
// timestep, three neurons) with a spike scoreboard per instance.
module tb_spike_residue_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] cfg_we, in_valid, spk_ready, ts_end;
  logic [7:0] cfg_thr [3];
  logic [7:0] in_psum [3];
  logic [1:0] in_id   [3];
  wire  [2:0] in_ready, spk_valid, ts_done, busy;
  wire  [1:0] spk_id0, spk_id1, spk_id2;

  int n_vec = 0;
  int n_err = 0;
  int mres [3][4];
  int mthr [3];
  int nn   [3];
  int nspk [3];
  int q0[$];
  int q1[$];
  int q2[$];

  spike_residue_sched #(.WIDTH(8), .NUM_NEURONS(4), .ID_W(2), .THRESHOLD(64), .CLEAR_ON_TS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we[0]), .cfg_threshold(cfg_thr[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_id(in_id[0]), .in_psum(in_psum[0]),
    .spk_valid(spk_valid[0]), .spk_ready(spk_ready[0]), .spk_id(spk_id0),
    .ts_end(ts_end[0]), .ts_done(ts_done[0]), .busy(busy[0]));

  spike_residue_sched #(.WIDTH(8), .NUM_NEURONS(4), .ID_W(2), .THRESHOLD(64), .CLEAR_ON_TS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we[1]), .cfg_threshold(cfg_thr[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_id(in_id[1]), .in_psum(in_psum[1]),
    .spk_valid(spk_valid[1]), .spk_ready(spk_ready[1]), .spk_id(spk_id1),
    .ts_end(ts_end[1]), .ts_done(ts_done[1]), .busy(busy[1]));

  spike_residue_sched #(.WIDTH(8), .NUM_NEURONS(3), .ID_W(2), .THRESHOLD(64), .CLEAR_ON_TS(1'b0)) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we[2]), .cfg_threshold(cfg_thr[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_id(in_id[2]), .in_psum(in_psum[2]),
    .spk_valid(spk_valid[2]), .spk_ready(spk_ready[2]), .spk_id(spk_id2),
    .ts_end(ts_end[2]), .ts_done(ts_done[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int probe(input int k, input int i);
    case (k)
      0: return int'(dut0.res_q[i]);
      1: return int'(dut1.res_q[i]);
      2: return int'(dut2.res_q[i]);
      default: return -1;
    endcase
  endfunction

  task automatic chk_res(input int k);
    for (int i = 0; i < nn[k]; i++)
      chk($sformatf("res%0d_%0d", k, i), 32'(probe(k, i)), 32'(mres[k][i]));
  endtask

  task automatic push(input int k, input int id);
    case (k)
      0: q0.push_back(id);
      1: q1.push_back(id);
      default: q2.push_back(id);
    endcase
  endtask

  // Wait (bounded) for in_ready, present one request for one cycle, and
  // update the reference residue/threshold model.
  task automatic send(input int k, input int id, input int ps);
    int n;
    int s;
    n = 0;
    while (in_ready[k] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk($sformatf("ready_wait%0d", k), 32'(in_ready[k]), 32'd1);
    in_valid[k] = 1'b1;
    in_id[k]    = id[1:0];
    in_psum[k]  = ps[7:0];
    tick();
    in_valid[k] = 1'b0;
    if (id < nn[k]) begin
      s = mres[k][id] + ps;
      if (s > 255) s = 255;
      if (s > mthr[k]) begin
        mres[k][id] = s - mthr[k];
        push(k, id);
      end else begin
        mres[k][id] = s;
      end
    end
  endtask

  task automatic cfg(input int k, input int v);
    cfg_we[k]  = 1'b1;
    cfg_thr[k] = v[7:0];
    tick();
    cfg_we[k]  = 1'b0;
    mthr[k]    = v;
  endtask

  task automatic spk_seen(input int k, input logic [1:0] id);
    int e;
    e = -1;
    nspk[k]++;
    case (k)
      0: if (q0.size() > 0) e = q0.pop_front();
      1: if (q1.size() > 0) e = q1.pop_front();
      default: if (q2.size() > 0) e = q2.pop_front();
    endcase
    chk($sformatf("spk_id%0d", k), 32'(id), 32'(e));
  endtask

  // Spike monitor: a handshake visible at the falling edge completes at the
  // next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (spk_valid[0] && spk_ready[0]) spk_seen(0, spk_id0);
      if (spk_valid[1] && spk_ready[1]) spk_seen(1, spk_id1);
      if (spk_valid[2] && spk_ready[2]) spk_seen(2, spk_id2);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    cfg_we = '0; in_valid = '0; ts_end = '0; spk_ready = 3'b111;
    nn[0] = 4; nn[1] = 4; nn[2] = 3;
    for (int k = 0; k < 3; k++) begin
      cfg_thr[k] = '0; in_psum[k] = '0; in_id[k] = '0;
      mthr[k] = 64; nspk[k] = 0;
      for (int i = 0; i < 4; i++) mres[k][i] = 0;
    end

    // Reset and initial clear sweep
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
    chk("rst_spk_valid", 32'(spk_valid[0]), 32'd0);
    chk("rst_spk_id", 32'(spk_id0), 32'd0);
    chk("rst_ts_done", 32'(ts_done[0]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk("sweep_busy", 32'(busy[0]), 32'd1);
      tick();
    end
    chk("sweep_done_busy", 32'(busy[0]), 32'd0);
    chk("sweep_done_ready", 32'(in_ready[0]), 32'd1);
    chk_res(0); chk_res(1); chk_res(2);

    // Sub-threshold accumulation then crossing
    send(0, 1, 30);
    chk("calc_not_ready", 32'(in_ready[0]), 32'd0);
    tick();
    chk("ready_t2", 32'(in_ready[0]), 32'd1);
    chk("no_spike", 32'(spk_valid[0]), 32'd0);
    send(0, 1, 30);
    tick(); tick();
    chk_res(0);
    send(0, 1, 10);
    tick();
    chk("spike_valid", 32'(spk_valid[0]), 32'd1);
    chk("spike_id", 32'(spk_id0), 32'd1);
    tick();
    chk("ready_after_hs", 32'(in_ready[0]), 32'd1);
    chk_res(0);

    // Equal-to-threshold and saturation
    send(0, 2, 64);
    tick(); tick();
    send(0, 3, 200);
    send(0, 3, 200);
    tick(); tick(); tick();
    chk_res(0);

    // Programmed threshold, then threshold of zero
    cfg(0, 10);
    send(0, 0, 11);
    tick(); tick(); tick();
    chk_res(0);
    cfg(0, 0);
    send(0, 2, 0);
    tick(); tick(); tick();
    chk_res(0);
    cfg(0, 64);

    // Backpressure on the spike channel
    tick(); tick();
    spk_ready[0] = 1'b0;
    base = nspk[0];
    send(0, 0, 100);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(spk_valid[0]), 32'd1);
      chk("bp_id", 32'(spk_id0), 32'd0);
      chk("bp_ready", 32'(in_ready[0]), 32'd0);
      tick();
    end
    spk_ready[0] = 1'b1;
    tick(); tick();
    chk("bp_one_spike", 32'(nspk[0] - base), 32'd1);
    chk_res(0);

    // Timestep end collides with a request
    tick();
    ts_end[0] = 1'b1; in_valid[0] = 1'b1; in_id[0] = 2'd0; in_psum[0] = 8'd5;
    #1;
    chk("ts_gates_ready", 32'(in_ready[0]), 32'd0);
    tick();
    ts_end[0] = 1'b0; in_valid[0] = 1'b0;
    chk("ts_done_pulse", 32'(ts_done[0]), 32'd1);
    chk("ts_idle", 32'(busy[0]), 32'd0);
    tick();
    chk("ts_done_once", 32'(ts_done[0]), 32'd0);
    chk("ts_ready_back", 32'(in_ready[0]), 32'd1);
    chk_res(0);

    // Clear on timestep end
    send(1, 2, 50);
    tick(); tick();
    chk_res(1);
    ts_end[1] = 1'b1;
    tick();
    ts_end[1] = 1'b0;
    chk("cts_pend_idle", 32'(busy[1]), 32'd0);
    chk("cts_pend_ready", 32'(in_ready[1]), 32'd0);
    chk("cts_pend_done", 32'(ts_done[1]), 32'd0);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("cts_busy", 32'(busy[1]), 32'd1);
      chk("cts_done", 32'(ts_done[1]), (c == 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("cts_exit_busy", 32'(busy[1]), 32'd0);
    chk("cts_exit_done", 32'(ts_done[1]), 32'd0);
    chk("cts_exit_ready", 32'(in_ready[1]), 32'd1);
    for (int i = 0; i < 4; i++) mres[1][i] = 0;
    chk_res(1);

    // Out-of-range id on a three-neuron instance
    send(2, 1, 20);
    tick(); tick();
    send(2, 3, 250);
    chk("bad_id_calc", 32'(busy[2]), 32'd1);
    tick();
    chk("bad_id_no_spike", 32'(spk_valid[2]), 32'd0);
    chk("bad_id_ready", 32'(in_ready[2]), 32'd1);
    chk_res(2);
    chk("bad_id_spikes", 32'(nspk[2]), 32'd0);

    // Reset during a stalled spike with a pending timestep end
    spk_ready[0] = 1'b0;
    send(0, 1, 100);
    tick();
    chk("mid_spike", 32'(spk_valid[0]), 32'd1);
    ts_end[0] = 1'b1;
    tick();
    ts_end[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q0.delete();
    spk_ready[0] = 1'b1;
    chk("mid_rst_spk", 32'(spk_valid[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      mthr[k] = 64;
      for (int i = 0; i < 4; i++) mres[k][i] = 0;
    end
    for (int c = 0; c < 4; c++) begin
      chk("mid_rst_busy", 32'(busy[0]), 32'd1);
      chk("mid_rst_no_done", 32'(ts_done[0]), 32'd0);
      tick();
    end
    chk("mid_rst_ready", 32'(in_ready[0]), 32'd1);
    chk("mid_rst_pend_dropped", 32'(ts_done[0]), 32'd0);
    tick();
    chk("mid_rst_pend_dropped2", 32'(ts_done[0]), 32'd0);
    chk_res(0); chk_res(1); chk_res(2);

    tick(); tick();
    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    chk("q2_empty", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spike_residue_sched.md
# spike_residue_sched

Clocked controller that time-shares a single threshold/residue datapath among `NUM_NEURONS` neurons. It holds one residue register per neuron and accepts tagged partial sums over a valid/ready channel. For each accepted partial sum it adds the sum to that neuron's stored residue, compares the result against a programmable threshold, writes the new residue back, and emits a spike event tagged with the neuron id. It sits between the PE accumulation stage and the spike output network, and it sequences per-timestep residue clearing.

## Interface
Parameters:
- `WIDTH`, 8: residue, partial-sum and threshold width.
- `NUM_NEURONS`, 4: number of neurons sharing the datapath; must be ≥ 2.
- `ID_W`, 2: neuron id width; must be ≥ clog2(`NUM_NEURONS`).
- `THRESHOLD`, 64: reset value of the threshold register.
- `CLEAR_ON_TS`, 0: when 1, all residues are cleared at each timestep end.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: write enable for the threshold register.
- `cfg_threshold` in `WIDTH`: new threshold value.
- `in_valid` in 1: partial-sum request valid.
- `in_ready` out 1: controller can accept a partial sum.
- `in_id` in `ID_W`: target neuron of the request.
- `in_psum` in `WIDTH`: unsigned partial sum.
- `spk_valid` out 1: spike event valid.
- `spk_ready` in 1: downstream accepts the spike.
- `spk_id` out `ID_W`: id of the neuron that fired.
- `ts_end` in 1: timestep-end pulse.
- `ts_done` out 1: one-cycle acknowledge of a serviced `ts_end`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- State machine states: CLEAR, IDLE, CALC, SPIKE.
- CLEAR:
  - Writes 0 to one residue entry per cycle, ascending from index 0.
  - After entry `NUM_NEURONS`-1 is written, moves to IDLE.
- IDLE:
  - `in_ready`=1 unless `ts_end` is high or a pending `ts_end` is latched.
  - On `in_valid && in_ready`, registers `in_id` and `in_psum` and moves to CALC.
- CALC:
  - Computes sum = residue[id] + psum at `WIDTH`+1 bits, saturated to 2^`WIDTH`-1.
  - If sum > thr (strictly greater): residue[id] = sum - thr, go to SPIKE.
  - Otherwise: residue[id] = sum, go to IDLE.
- SPIKE:
  - `spk_valid`=1 and `spk_id`=id, both held stable until `spk_ready`.
  - On the handshake, moves to IDLE.
- Out-of-range `in_id` (≥ `NUM_NEURONS`): the request is accepted and dropped. No residue write, no spike; the FSM returns to IDLE from CALC.
- Threshold register:
  - Loaded from `cfg_threshold` whenever `cfg_we`=1, in any state.
  - CALC uses the value registered at the start of the CALC cycle.
  - thr=0: any nonzero sum fires.
- `ts_end` handling:
  - A `ts_end` in any state sets a pending flag. Repeated pulses while the flag is set collapse into one.
  - The flag is serviced in IDLE and has priority over `in_valid`, which is not accepted that cycle.
  - Service with `CLEAR_ON_TS`=0: pulse `ts_done` and stay in IDLE.
  - Service with `CLEAR_ON_TS`=1: enter CLEAR; `ts_done` pulses on the cycle CLEAR exits to IDLE.
- No combinational path from any input to `in_ready` or `spk_valid`, except the `ts_end` gating of `in_ready`.

## Timing
- Reset values:
  - State = CLEAR; residues are cleared by the CLEAR sweep (`NUM_NEURONS` cycles).
  - thr = `THRESHOLD`; pending flag = 0.
  - `in_ready`=0, `spk_valid`=0, `spk_id`=0, `ts_done`=0, `busy`=1.
- `rst` asserted mid-operation:
  - A pending spike is discarded and the pending `ts_end` is dropped.
  - CLEAR restarts from index 0 on the cycle after `rst` deasserts.
- Input accepted at edge t:
  - CALC during cycle t+1.
  - No spike: `in_ready`=1 again at t+2, giving a maximum throughput of one request per 2 cycles.
  - Spike: `spk_valid`=1 from t+2; `in_ready` is re-enabled the cycle after the spike handshake.
- `spk_ready` tied high: a firing request occupies 3 cycles.
- Back-to-back requests to the same id: the second uses the residue written by the first, with no hazard window.
- `ts_done` is exactly one cycle wide.

## Test plan
- Reset sweep:
  - Stimulus: `rst` for 2 cycles, then release.
  - Response: `busy`=1 for 4 cycles, then `in_ready`=1; all residues read back 0 via probes.
- Sub-threshold accumulation:
  - Stimulus: id 1 receives psum 30 then 30.
  - Response: no spike, residue[1]=60.
  - Stimulus: a further psum 10.
  - Response: sum 70 > 64, so `spk_valid` with `spk_id`=1 and residue[1]=6.
- Boundary and saturation:
  - id 2 receives psum 64: no spike (not strictly greater).
  - id 3 receives 200 then 200: saturates to 255, spikes, residue[3]=191.
- Backpressure:
  - Stimulus: a spike on id 0 with `spk_ready`=0 for 5 cycles.
  - Response: `spk_valid` and `spk_id` stable throughout; `in_ready`=0; exactly one spike counted.
- Timestep end:
  - `ts_end` asserted together with `in_valid`: the request is not accepted and `ts_done` pulses.
  - With `CLEAR_ON_TS`=1: `ts_done` pulses after a 4-cycle CLEAR and all residues read 0.
- Config and illegal id:
  - Stimulus: `cfg_we` sets thr=10, then id 0 receives psum 11.
  - Response: spike with residue 1.
  - Stimulus (`NUM_NEURONS`=3): `in_id`=3.
  - Response: accepted, no spike, no residue changes.
